// File: rtl/bram_burst_master.sv
// bram_burst_master: burst initiator for a single-port BRAM (en/wren/addr/d_in/d_out).
// Ports: clk/rst; cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len burst command;
//   wr_data/wr_valid/wr_ready write stream in; rd_data/rd_valid/rd_ready read stream out;
//   done pulse, busy; bram_en/bram_wren/bram_addr/bram_d_in (registered), bram_d_out.
// Optional: define BRAM_MASTER_STATS_EN to add stat_wr_words/stat_rd_words counters.
module bram_burst_master #(
  parameter int p_addr_bits    = 14,
  parameter int p_read_latency = 2,
  parameter int p_len_bits     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [p_addr_bits-1:0] cmd_addr,
  input  logic [p_len_bits-1:0]  cmd_len,
  input  logic [31:0]            wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [31:0]            rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   done,
  output logic                   busy,
  output logic                   bram_en,
  output logic                   bram_wren,
  output logic [p_addr_bits-1:0] bram_addr,
  output logic [31:0]            bram_d_in,
  input  logic [31:0]            bram_d_out
`ifdef BRAM_MASTER_STATS_EN
  ,
  output logic [31:0]            stat_wr_words,
  output logic [31:0]            stat_rd_words
`endif
);

  localparam int L  = p_read_latency;
  localparam int D  = p_read_latency + 2;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1) + 1;
  localparam int RW = p_len_bits + 1;
  localparam int AW = p_addr_bits;

  typedef enum logic [1:0] {
    S_IDLE, S_WRITE, S_READ, S_DRAIN
  } state_t;

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [RW-1:0] rem_q;
  logic          en_q;
  logic          wren_q;
  logic          wdone_q;
  logic [AW-1:0] baddr_q;
  logic [31:0]   bdin_q;
  logic [L-1:0]  sr_q;
  logic [L-1:0]  sr_d;
  logic [31:0]   fifo_q [D];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] outst;
  logic [CW-1:0] occ;
  logic          rd_inflight;
  logic          rem_one;
  logic          wr_hs;
  logic          push;
  logic          pop;
  logic          issue;
  logic          rd_last;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reads in flight: the read on the BRAM pins now plus every tag
  // still travelling down the latency shift register.
  always_comb begin
    rd_inflight = en_q & ~wren_q;
    outst = CW'(rd_inflight);
    for (int i = 0; i < L; i++) begin
      outst = outst + CW'(sr_q[i]);
    end
    occ = outst + cnt_q;
  end

  assign sr_d      = L'({sr_q, rd_inflight});
  assign rem_one   = (rem_q == RW'(1));
  assign wr_ready  = (state_q == S_WRITE) && (rem_q != '0);
  assign wr_hs     = wr_valid && wr_ready;
  assign rd_valid  = (cnt_q != '0);
  assign rd_data   = rd_valid ? fifo_q[head_q] : '0;
  assign pop       = rd_valid && rd_ready;
  assign push      = sr_q[L-1];
  assign issue     = (state_q == S_READ) && (rem_q != '0)
                     && (occ < CW'(D));
  assign rd_last   = (state_q == S_DRAIN) && (outst == '0)
                     && (cnt_q == CW'(1)) && rd_ready;
  assign done      = wdone_q | rd_last;
  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign bram_en   = en_q;
  assign bram_wren = wren_q;
  assign bram_addr = baddr_q;
  assign bram_d_in = bdin_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      en_q    <= 1'b0;
      wren_q  <= 1'b0;
      wdone_q <= 1'b0;
      baddr_q <= '0;
      bdin_q  <= '0;
    end else begin
      en_q    <= 1'b0;
      wren_q  <= 1'b0;
      wdone_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            rem_q   <= {1'b0, cmd_len} + RW'(1);
            state_q <= cmd_write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wr_hs) begin
            en_q    <= 1'b1;
            wren_q  <= 1'b1;
            baddr_q <= addr_q;
            bdin_q  <= wr_data;
            addr_q  <= addr_q + AW'(1);
            rem_q   <= rem_q - RW'(1);
            wdone_q <= rem_one;
          end else if (rem_q == '0) begin
            // final write is on the pins this cycle
            state_q <= S_IDLE;
          end
        end
        S_READ: begin
          if (issue) begin
            en_q    <= 1'b1;
            baddr_q <= addr_q;
            addr_q  <= addr_q + AW'(1);
            rem_q   <= rem_q - RW'(1);
            if (rem_one) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rd_last) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      sr_q <= sr_d;
      if (push) tail_q <= nxt(tail_q);
      if (pop)  head_q <= nxt(head_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= bram_d_out;
  end

  // Issue throttling must keep the return FIFO from ever overflowing.
  always @(posedge clk) begin
    if (!rst) assert (!(push && !pop && cnt_q == CW'(D)));
  end

`ifdef BRAM_MASTER_STATS_EN
  logic [31:0] stat_wr_q;
  logic [31:0] stat_rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      if (wr_hs) stat_wr_q <= stat_wr_q + 32'd1;
      if (pop)   stat_rd_q <= stat_rd_q + 32'd1;
    end
  end

  assign stat_wr_words = stat_wr_q;
  assign stat_rd_words = stat_rd_q;
`endif

endmodule

// File: tb/tb_bram_burst_master.sv
// tb_bram_burst_master: directed bench for bram_burst_master with a BRAM model,
// a transaction-level reference (queues of expected accesses/words) and literal pins.
module tb_bram_burst_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [13:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        done;
  logic        busy;
  logic        bram_en;
  logic        bram_wren;
  logic [13:0] bram_addr;
  logic [31:0] bram_d_in;
  logic [31:0] bram_d_out;
`ifdef BRAM_MASTER_STATS_EN
  logic [31:0] stat_wr_words;
  logic [31:0] stat_rd_words;
`endif

  bram_burst_master #(
    .p_addr_bits(14),
    .p_read_latency(2),
    .p_len_bits(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .done(done),
    .busy(busy),
    .bram_en(bram_en),
    .bram_wren(bram_wren),
    .bram_addr(bram_addr),
    .bram_d_in(bram_d_in),
    .bram_d_out(bram_d_out)
`ifdef BRAM_MASTER_STATS_EN
    ,
    .stat_wr_words(stat_wr_words),
    .stat_rd_words(stat_rd_words)
`endif
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: two register stages, data valid two cycles after en is seen.
  bit [31:0] bram_mem [16384];
  logic [31:0] r1 = '0;
  logic [31:0] dout_q = '0;
  assign bram_d_out = dout_q;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_wren) bram_mem[bram_addr] <= bram_d_in;
      else r1 <= bram_mem[bram_addr];
    end
    dout_q <= r1;
  end

  int checks = 0;
  int errs = 0;

  function automatic void chk(input string nm, input logic [127:0] act,
                              input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(input string nm);
    checks++;
    errs++;
    $display("FAIL %s", nm);
  endfunction

  // Reference model state
  bit [31:0]   ref_mem [16384];
  logic [13:0] exp_waddr [$];
  logic [31:0] exp_wdata [$];
  logic [13:0] exp_raddr [$];
  logic [31:0] exp_rq [$];
  int rd_issued = 0;
  int rd_popped = 0;
  logic hold_pend = 1'b0;
  logic [31:0] hold_data = '0;

  // Logs for literal pins
  int wr_cyc_log [$];
  int rd_cyc_log [$];
  logic [31:0] rd_log [$];
  int first_rv = -1;
  int done_cyc = -1;
  int last_h = 0;
  int rd_mode = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (rd_mode == 1) rd_ready = ~rd_ready;
    else rd_ready = 1'b1;
  end

  logic ev_last;
  always @(negedge clk) begin
    if (!rst) begin
      ev_last = 1'b0;
      if (bram_en && cmd_ready) fail("bram_access_in_idle");
      if (hold_pend) chk("rd_hold", {rd_valid, rd_data}, {1'b1, hold_data});
      hold_pend = rd_valid && !rd_ready;
      hold_data = rd_data;
      if (bram_en && bram_wren) begin
        wr_cyc_log.push_back(cyc);
        if (exp_waddr.size() == 0) fail("unexpected_write");
        else begin
          chk("wr_addr", bram_addr, exp_waddr.pop_front());
          chk("wr_data", bram_d_in, exp_wdata.pop_front());
          if (exp_waddr.size() == 0) ev_last = 1'b1;
        end
      end
      if (bram_en && !bram_wren) begin
        rd_issued++;
        if (exp_raddr.size() == 0) fail("unexpected_read");
        else chk("rd_addr", bram_addr, exp_raddr.pop_front());
        chk("occupancy_le4", (rd_issued - rd_popped) <= 4, 1'b1);
      end
      if (rd_valid && first_rv < 0) first_rv = cyc;
      if (rd_valid && rd_ready) begin
        rd_popped++;
        rd_log.push_back(rd_data);
        rd_cyc_log.push_back(cyc);
        if (exp_rq.size() == 0) fail("unexpected_rd_word");
        else begin
          chk("rd_data", rd_data, exp_rq.pop_front());
          if (exp_rq.size() == 0) ev_last = 1'b1;
        end
      end
      chk("done", done, ev_last);
      if (done) done_cyc = cyc;
    end
  end

  task automatic clear_logs();
    wr_cyc_log.delete();
    rd_cyc_log.delete();
    rd_log.delete();
    first_rv = -1;
    done_cyc = -1;
  endtask

  task automatic issue_cmd(input logic w, input logic [13:0] a,
                           input logic [7:0] len);
    int n;
    logic ok;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_len = len;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    last_h = cyc;
    if (!ok) fail("cmd_timeout");
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    logic ok;
    wr_valid = 1'b1;
    wr_data = w;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = wr_ready;
      @(posedge clk);
      #1;
      n++;
    end
    wr_valid = 1'b0;
    if (!ok) fail("wr_timeout");
  endtask

  task automatic wait_done();
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    @(posedge clk);
    #1;
    if (!seen) fail("done_timeout");
  endtask

  task automatic wr_burst(input logic [13:0] a, input int len,
                          input logic [31:0] base, input int gap);
    for (int i = 0; i <= len; i++) begin
      exp_waddr.push_back(a + 14'(i));
      exp_wdata.push_back(base + 32'(i));
      ref_mem[a + 14'(i)] = base + 32'(i);
    end
    issue_cmd(1'b1, a, 8'(len));
    for (int i = 0; i <= len; i++) begin
      send_word(base + 32'(i));
      if (gap > 0 && (i % gap) == gap - 1) begin
        @(posedge clk);
        #1;
      end
    end
    wait_done();
    chk("wq_drained", exp_waddr.size(), 0);
  endtask

  task automatic rd_burst(input logic [13:0] a, input int len);
    for (int i = 0; i <= len; i++) begin
      exp_raddr.push_back(a + 14'(i));
      exp_rq.push_back(ref_mem[a + 14'(i)]);
    end
    issue_cmd(1'b0, a, 8'(len));
    wait_done();
    chk("rq_drained", exp_rq.size(), 0);
  endtask

  function automatic logic [127:0] all_outs();
    return {cmd_ready, wr_ready, rd_valid, done, busy, bram_en, bram_wren,
            rd_data, bram_addr, bram_d_in};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), '0);
    #3;
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_reset", {cmd_ready, busy}, 2'b10);
    @(posedge clk);
    #1;

    // Write 0x10..0x13, back-to-back stream
    clear_logs();
    wr_burst(14'h0010, 3, 32'h0000_00A0, 0);
    chk("wr_count", wr_cyc_log.size(), 4);
    chk("wr_first_cycle", wr_cyc_log[0], last_h + 1);
    chk("wr_last_cycle", wr_cyc_log[3], last_h + 4);
    chk("wr_done_cycle", done_cyc, last_h + 4);
    for (int i = 0; i < 4; i++)
      chk("bram_content", bram_mem[14'h10 + 14'(i)], 32'hA0 + 32'(i));

    // Read back with rd_ready held high
    rd_mode = 0;
    clear_logs();
    rd_burst(14'h0010, 3);
    chk("rd_first_valid", first_rv, last_h + 4);
    chk("rd_count", rd_log.size(), 4);
    chk("rd_word0", rd_log[0], 32'hA0);
    chk("rd_word3", rd_log[3], 32'hA3);
    chk("rd_consecutive", rd_cyc_log[3] - rd_cyc_log[0], 3);
    chk("rd_done_cycle", done_cyc, rd_cyc_log[3]);
`ifdef BRAM_MASTER_STATS_EN
    chk("stat_wr_words", stat_wr_words, 32'd4);
    chk("stat_rd_words", stat_rd_words, 32'd4);
`endif

    // 16-word write with stream gaps, then read with rd_ready toggling
    wr_burst(14'h0100, 15, 32'h1000_0000, 3);
    rd_mode = 1;
    clear_logs();
    rd_burst(14'h0100, 15);
    chk("toggle_rd_count", rd_log.size(), 16);
    chk("toggle_rd_last", rd_log[15], 32'h1000_000F);
    rd_mode = 0;
    @(posedge clk);
    #1;

    // Address wrap on writes and reads
    wr_burst(14'h3FFE, 3, 32'hC0DE_0000, 0);
    chk("wrap_3ffe", bram_mem[14'h3FFE], 32'hC0DE_0000);
    chk("wrap_3fff", bram_mem[14'h3FFF], 32'hC0DE_0001);
    chk("wrap_0000", bram_mem[14'h0000], 32'hC0DE_0002);
    chk("wrap_0001", bram_mem[14'h0001], 32'hC0DE_0003);
    clear_logs();
    rd_burst(14'h3FFE, 3);
    chk("wrap_rd_word2", rd_log[2], 32'hC0DE_0002);

    // Reset with two reads in flight
    for (int i = 0; i <= 15; i++) begin
      exp_raddr.push_back(14'h0100 + 14'(i));
      exp_rq.push_back(ref_mem[14'h0100 + 14'(i)]);
    end
    issue_cmd(1'b0, 14'h0100, 8'd15);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midburst_reset_outputs", all_outs(), '0);
    exp_raddr.delete();
    exp_rq.delete();
    exp_waddr.delete();
    exp_wdata.delete();
    rd_issued = 0;
    rd_popped = 0;
    hold_pend = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", {cmd_ready, busy}, 2'b10);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_rd_valid", rd_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    clear_logs();
    rd_burst(14'h0010, 3);
    chk("post_reset_rd_count", rd_log.size(), 4);
    chk("post_reset_rd_word0", rd_log[0], 32'hA0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
